// File: rtl/serial_pkg.sv
// Shared types and line levels for the bit-serial transmitter.
package serial_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    localparam logic TX_IDLE_LEVEL = 1'b1;
    localparam logic START_LEVEL   = 1'b0;
    localparam logic STOP_LEVEL    = 1'b1;

endpackage

// File: rtl/bit_tick_gen.sv
// Bit-period timer: tick pulses on the last clock of every BIT_CYCLES-clock bit.
// While clear is high the count is held at zero, so the first bit after clear is full length.
module bit_tick_gen #(
    parameter int BIT_CYCLES = 4
) (
    input  logic Clk,
    input  logic Resetn,
    input  logic clear,
    output logic tick
);

    localparam int            CW   = $clog2(BIT_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(BIT_CYCLES - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn)
            r_cnt <= '0;
        else if (clear || tick)
            r_cnt <= '0;
        else
            r_cnt <= r_cnt + CW'(1);
    end

    assign tick = !clear && (r_cnt == LAST);

endmodule

// File: rtl/serial_bit_tx.sv
// Bit-serial transmitter: start bit, WIDTH data bits LSB first, optional even parity, stop bit.
// Define SERIAL_TX_PARITY_EN to insert the parity bit between the data bits and the stop bit.
module serial_bit_tx
    import serial_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int BIT_CYCLES = 4
) (
    input  logic             Clk,
    input  logic             Resetn,
    input  logic             Load,
    input  logic [WIDTH-1:0] Data,
    output logic             Tx,
    output logic             Busy,
    output logic             Done
);

    localparam int            BW       = $clog2(WIDTH + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

    tx_state_t        r_state;
    logic [WIDTH-1:0] r_shift;
    logic [BW-1:0]    r_bit_cnt;
    logic             r_tx;
    logic             r_busy;
    logic             w_tick;
    logic             w_clear;
    logic [WIDTH-1:0] w_shift_nxt;
`ifdef SERIAL_TX_PARITY_EN
    logic             r_parity;
`endif

    // Timer is parked in IDLE so the start bit always gets its full BIT_CYCLES.
    assign w_clear     = (r_state == IDLE);
    assign w_shift_nxt = r_shift >> 1;

    bit_tick_gen #(.BIT_CYCLES(BIT_CYCLES)) u_tick (
        .Clk    (Clk),
        .Resetn (Resetn),
        .clear  (w_clear),
        .tick   (w_tick)
    );

    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            r_state   <= IDLE;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_tx      <= TX_IDLE_LEVEL;
            r_busy    <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
            r_parity  <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    r_tx <= TX_IDLE_LEVEL;
                    if (Load) begin
                        r_shift   <= Data;
                        r_bit_cnt <= '0;
                        r_busy    <= 1'b1;
                        r_tx      <= START_LEVEL;
                        r_state   <= START;
`ifdef SERIAL_TX_PARITY_EN
                        r_parity  <= ^Data;
`endif
                    end
                end
                START: if (w_tick) begin
                    r_tx    <= r_shift[0];
                    r_state <= DATA;
                end
                DATA: if (w_tick) begin
                    if (r_bit_cnt == LAST_BIT) begin
                        r_bit_cnt <= '0;
`ifdef SERIAL_TX_PARITY_EN
                        r_tx      <= r_parity;
                        r_state   <= PARITY;
`else
                        r_tx      <= STOP_LEVEL;
                        r_state   <= STOP;
`endif
                    end else begin
                        r_shift   <= w_shift_nxt;
                        r_tx      <= w_shift_nxt[0];
                        r_bit_cnt <= r_bit_cnt + BW'(1);
                    end
                end
`ifdef SERIAL_TX_PARITY_EN
                PARITY: if (w_tick) begin
                    r_tx    <= STOP_LEVEL;
                    r_state <= STOP;
                end
`endif
                STOP: if (w_tick) begin
                    r_busy  <= 1'b0;
                    r_tx    <= TX_IDLE_LEVEL;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign Tx   = r_tx;
    assign Busy = r_busy;
    // Decoded from state and timer flops only; high on the final stop-bit clock.
    assign Done = (r_state == STOP) && w_tick;

endmodule

// File: tb/tb_serial_bit_tx.sv
// Directed bench for serial_bit_tx: BIT_CYCLES=4 and BIT_CYCLES=1 instances, per-clock expected line queue.
module tb_serial_bit_tx;

    localparam int W = 8;
`ifdef SERIAL_TX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       load_a, load_b;
    logic [7:0] data;
    logic       tx_a, busy_a, done_a;
    logic       tx_b, busy_b, done_b;

    always #5 clk = ~clk;

    serial_bit_tx #(.WIDTH(W), .BIT_CYCLES(4)) u_a (
        .Clk(clk), .Resetn(rst_n), .Load(load_a), .Data(data),
        .Tx(tx_a), .Busy(busy_a), .Done(done_a)
    );

    serial_bit_tx #(.WIDTH(W), .BIT_CYCLES(1)) u_b (
        .Clk(clk), .Resetn(rst_n), .Load(load_b), .Data(data),
        .Tx(tx_b), .Busy(busy_b), .Done(done_b)
    );

    int   n_chk  = 0;
    int   n_fail = 0;
    logic exp_q[$];

    task automatic check(input string tag, input logic obs, input logic exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic set_load(input logic sel, input logic v);
        if (sel) load_b = v;
        else     load_a = v;
    endtask

    // Expected line level for every clock of one frame.
    task automatic push_frame(input logic [7:0] d, input int bc);
        for (int c = 0; c < bc; c++) exp_q.push_back(1'b0);
        for (int i = 0; i < W; i++)
            for (int c = 0; c < bc; c++) exp_q.push_back(d[i]);
        if (PB == 1)
            for (int c = 0; c < bc; c++) exp_q.push_back(^d);
        for (int c = 0; c < bc; c++) exp_q.push_back(1'b1);
    endtask

    // Walks one frame clock by clock starting the cycle after the load edge.
    task automatic check_frame(input logic sel, input int bc, input int drop_at,
                               input int repulse_at, input int abort_at);
        int   fl;
        logic e;
        fl = (W + 2 + PB) * bc;
        for (int k = 1; k <= fl; k++) begin
            @(negedge clk);
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 1'bx;
            check($sformatf("tx%0d[%0d]", sel, k), sel ? tx_b : tx_a, e);
            check($sformatf("busy%0d[%0d]", sel, k), sel ? busy_b : busy_a, 1'b1);
            check($sformatf("done%0d[%0d]", sel, k), sel ? done_b : done_a, k == fl);
            if (k == drop_at) set_load(sel, 1'b0);
            if (k == repulse_at) begin
                data = 8'hFF;
                set_load(sel, 1'b1);
            end
            if (repulse_at > 0 && k == repulse_at + 4) set_load(sel, 1'b0);
            if (k == abort_at) break;
        end
    endtask

    task automatic idle_check(input logic sel);
        @(negedge clk);
        check($sformatf("idle_tx%0d", sel), sel ? tx_b : tx_a, 1'b1);
        check($sformatf("idle_busy%0d", sel), sel ? busy_b : busy_a, 1'b0);
        check($sformatf("idle_done%0d", sel), sel ? done_b : done_a, 1'b0);
    endtask

    task automatic start(input logic sel, input logic [7:0] d, input int bc);
        @(negedge clk);
        data = d;
        set_load(sel, 1'b1);
        push_frame(d, bc);
    endtask

    initial begin
        rst_n  = 1'b0;
        load_a = 1'b0;
        load_b = 1'b0;
        data   = 8'h00;
        repeat (2) @(negedge clk);
        check("rst_tx", tx_a, 1'b1);
        check("rst_busy", busy_a, 1'b0);
        check("rst_done", done_a, 1'b0);
        rst_n = 1'b1;
        repeat (10) begin
            idle_check(1'b0);
            check("idle_tx_b", tx_b, 1'b1);
        end

        // Basic frame
        start(1'b0, 8'hA5, 4);
        check_frame(1'b0, 4, 1, 0, 0);
        idle_check(1'b0);

        // Load re-pulsed with new data mid-frame is ignored
        start(1'b0, 8'hA5, 4);
        check_frame(1'b0, 4, 1, 10, 0);
        repeat (3) idle_check(1'b0);

        // Load held high: two frames with exactly one idle clock between them
        start(1'b0, 8'h3C, 4);
        check_frame(1'b0, 4, 0, 0, 0);
        idle_check(1'b0);
        push_frame(8'h3C, 4);
        check_frame(1'b0, 4, 1, 0, 0);
        idle_check(1'b0);

        // Async reset mid-frame, then a fresh full frame
        start(1'b0, 8'hA5, 4);
        check_frame(1'b0, 4, 1, 0, 17);
        rst_n = 1'b0;
        #1;
        check("arst_tx", tx_a, 1'b1);
        check("arst_busy", busy_a, 1'b0);
        check("arst_done", done_a, 1'b0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        idle_check(1'b0);
        start(1'b0, 8'hC3, 4);
        check_frame(1'b0, 4, 1, 0, 0);
        idle_check(1'b0);

        start(1'b0, 8'h01, 4);
        check_frame(1'b0, 4, 1, 0, 0);
        idle_check(1'b0);

        // One clock per bit
        start(1'b1, 8'hA5, 1);
        check_frame(1'b1, 1, 1, 0, 0);
        idle_check(1'b1);
        start(1'b1, 8'h01, 1);
        check_frame(1'b1, 1, 1, 0, 0);
        idle_check(1'b1);

        check("queue_empty", exp_q.size() == 0, 1'b1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
